// File: rtl/netfpga_pkg.sv
// Shared types and constants for the NetFPGA clock/reset slice.
// Imported by the reset sequencer and its synchroniser.
package netfpga_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_state_t;

    localparam int LOSS_W = 8;

endpackage

// File: rtl/netfpga_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
// Generic width so other CDC points can reuse it.
module netfpga_sync2 #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    logic [W-1:0] meta;

    // Two register stages; both clear to 0 so the output reads "not locked".
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta <= '0;
            Q    <= '0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/netfpga_rst_seq.sv
// Staged reset sequencer downstream of the DCM.
// Releases SYS_RST then USER_RST after a stable lock; counts lock losses.
module netfpga_rst_seq
    import netfpga_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int USER_DELAY    = 64,
    parameter int CNT_W         = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              DCM_LOCKED,
    input  logic              SOFT_RST,
    output logic              SYS_RST,
    output logic              USER_RST,
    output logic              READY,
    output logic [1:0]        STATE,
    output logic [LOSS_W-1:0] LOSS_CNT
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] USER_LAST   = CNT_W'(USER_DELAY - 1);

    rst_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lock_s;
    logic             drop;
    logic             loss;

    netfpga_sync2 #(
        .W(1)
    ) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .D    (DCM_LOCKED),
        .Q    (lock_s)
    );

    assign drop  = !lock_s || SOFT_RST;
    // Only a real lock loss out of a released state is a countable event.
    assign loss  = !lock_s && ((state == RELEASE) || (state == RUN));
    assign STATE = state;

    // Sequencer FSM; outputs are written with the next state so they move on the same edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= WAIT_LOCK;
            cnt      <= '0;
            SYS_RST  <= 1'b1;
            USER_RST <= 1'b1;
            READY    <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (!drop) state <= STABLE;
                end
                STABLE: begin
                    if (drop) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state   <= RELEASE;
                        cnt     <= '0;
                        SYS_RST <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (drop) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        SYS_RST <= 1'b1;
                    end else if (cnt == USER_LAST) begin
                        state    <= RUN;
                        cnt      <= '0;
                        USER_RST <= 1'b0;
                        READY    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (drop) begin
                        state    <= WAIT_LOCK;
                        cnt      <= '0;
                        SYS_RST  <= 1'b1;
                        USER_RST <= 1'b1;
                        READY    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Saturating lock-loss counter for status readout.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LOSS_CNT <= '0;
        end else if (loss && (LOSS_CNT != '1)) begin
            LOSS_CNT <= LOSS_CNT + 1'b1;
        end
    end

endmodule
